// File: rtl/stepper_move_arbiter_if.sv
// Requester/motor-side bundle of the stepper move arbiter: move requests in,
// grant/completion handshake, position and coil phases out.
interface stepper_move_arbiter_if #(
   parameter int CNT_W = 16,
   parameter int POS_W = 16
);
   logic             EN;
   logic [2:0]       req;
   logic [2:0]       dir;
   logic [CNT_W-1:0] steps_qr;
   logic [CNT_W-1:0] steps_geo;
   logic [CNT_W-1:0] steps_gps;
   logic [2:0]       gnt;
   logic [2:0]       done;
   logic             busy;
   logic [POS_W-1:0] pos;
   logic [3:0]       M_OUT;

   modport master (
      output EN, req, dir, steps_qr, steps_geo, steps_gps,
      input  gnt, done, busy, pos, M_OUT
   );

   modport slave (
      input  EN, req, dir, steps_qr, steps_geo, steps_gps,
      output gnt, done, busy, pos, M_OUT
   );
endinterface

// File: rtl/stepper_move_arbiter.sv
// Round-robin arbiter sharing one full-step phase driver between the QR,
// heading and latitude move requesters; paces steps and tracks position.
module stepper_move_arbiter #(
   parameter int STEP_DIV = 1000,
   parameter int CNT_W    = 16,
   parameter int POS_W    = 16,
   parameter int SETTLE   = 100
) (
   input logic                 CLK,
   input logic                 RST,
   stepper_move_arbiter_if.slave bus
);
   localparam int TMR_W = $clog2(STEP_DIV);
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_SETTLE} state_t;

   state_t           state_q, state_n;
   logic [2:0]       gnt_q, gnt_n, done_q, done_n;
   logic             busy_q, busy_n, dir_q, dir_n;
   logic [1:0]       ptr_q, ptr_n, win_idx;
   logic             win_vld;
   logic [POS_W-1:0] pos_q, pos_n;
   logic [3:0]       phase_q, phase_n;
   logic [CNT_W-1:0] rem_q, rem_n, steps_sel;
   logic [TMR_W-1:0] tmr_q, tmr_n;
   logic [SET_W-1:0] cnt_q, cnt_n;

   function automatic logic [1:0] rr_idx(input logic [1:0] p, input int i);
      int k;
      k = int'(p) + i;
      if (k >= 3) k = k - 3;
      return k[1:0];
   endfunction

   // From an unenergised (0000) or illegal pattern the reverse direction
   // enters at the top of the sequence; illegal patterns de-energise.
   function automatic logic [3:0] nxt_phase(input logic [3:0] ph, input logic fwd);
      case (ph)
         4'b0000: return fwd ? 4'b0001 : 4'b1000;
         4'b0001: return fwd ? 4'b0010 : 4'b1000;
         4'b0010: return fwd ? 4'b0100 : 4'b0001;
         4'b0100: return fwd ? 4'b1000 : 4'b0010;
         4'b1000: return fwd ? 4'b0001 : 4'b0100;
         default: return 4'b0000;
      endcase
   endfunction

   // Search starts one past the last winner, so a requester that stays
   // asserted falls behind everyone else still waiting.
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr_q;
      for (int i = 1; i <= 3; i++) begin
         if (!win_vld && bus.req[rr_idx(ptr_q, i)]) begin
            win_vld = 1'b1;
            win_idx = rr_idx(ptr_q, i);
         end
      end
   end

   always_comb begin
      case (win_idx)
         2'd0:    steps_sel = bus.steps_qr;
         2'd1:    steps_sel = bus.steps_geo;
         default: steps_sel = bus.steps_gps;
      endcase
   end

   always_comb begin
      state_n = state_q;
      gnt_n   = gnt_q;
      done_n  = done_q;
      ptr_n   = ptr_q;
      dir_n   = dir_q;
      pos_n   = pos_q;
      phase_n = phase_q;
      rem_n   = rem_q;
      tmr_n   = tmr_q;
      cnt_n   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.EN && win_vld) begin
               gnt_n   = 3'b001 << win_idx;
               ptr_n   = win_idx;
               dir_n   = bus.dir[win_idx];
               rem_n   = steps_sel;
               tmr_n   = TMR_W'(STEP_DIV - 1);
               state_n = (steps_sel == '0) ? S_ZERO : S_RUN;
            end
         end
         S_RUN, S_ZERO: begin
            // done is held for exactly one cycle, paused or not
            if (|done_q) begin
               done_n  = 3'b000;
               gnt_n   = 3'b000;
               cnt_n   = SET_W'(SETTLE - 1);
               state_n = S_SETTLE;
            end else if (state_q == S_ZERO) begin
               done_n = gnt_q;
            end else if (bus.EN) begin
               if (tmr_q != '0) begin
                  tmr_n = tmr_q - 1'b1;
               end else begin
                  phase_n = nxt_phase(phase_q, dir_q);
                  rem_n   = rem_q - 1'b1;
                  pos_n   = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
                  tmr_n   = TMR_W'(STEP_DIV - 1);
                  if (rem_q == CNT_W'(1)) done_n = gnt_q;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) state_n = S_IDLE;
            else             cnt_n   = cnt_q - 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign busy_n = (state_n != S_IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= 2'd2;
         dir_q   <= 1'b0;
         pos_q   <= '0;
         phase_q <= '0;
         rem_q   <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         done_q  <= done_n;
         busy_q  <= busy_n;
         ptr_q   <= ptr_n;
         dir_q   <= dir_n;
         pos_q   <= pos_n;
         phase_q <= phase_n;
         rem_q   <= rem_n;
         tmr_q   <= tmr_n;
         cnt_q   <= cnt_n;
      end
   end

   // Coils released whenever the motor is disabled; phase_q keeps the position.
   assign bus.M_OUT = bus.EN ? phase_q : 4'b0000;
   assign bus.gnt   = gnt_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.pos   = pos_q;
endmodule

// File: tb/tb_stepper_move_arbiter.sv
// Scoreboard bench for stepper_move_arbiter: stimulus queues expected
// grant/phase/done events with cycle stamps, a negedge monitor retires them.
module tb_stepper_move_arbiter;
   localparam int STEP_DIV = 4, SETTLE = 2, CNT_W = 16, POS_W = 16;

   typedef enum int {K_GNT, K_MOUT, K_DONE} kind_t;
   typedef struct {
      kind_t       k;
      int          c;
      logic [15:0] v;
      logic [15:0] p;
   } ev_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   ev_t  q[$];
   logic [2:0] pg = 3'b000;
   logic [3:0] pm = 4'b0000;

   stepper_move_arbiter_if #(.CNT_W(CNT_W), .POS_W(POS_W)) bus();

   stepper_move_arbiter #(.STEP_DIV(STEP_DIV), .CNT_W(CNT_W), .POS_W(POS_W), .SETTLE(SETTLE)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input kind_t k, input int c, input logic [15:0] v, input logic [15:0] p = 16'h0);
      ev_t e;
      e.k = k; e.c = c; e.v = v; e.p = p;
      q.push_back(e);
   endtask

   task automatic sb(input kind_t k, input logic [15:0] v, input logic [15:0] p);
      ev_t e;
      n_chk++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected: got %s val %h pos %h at cyc %0d, nothing expected", k.name(), v, p, cyc);
         return;
      end
      e = q.pop_front();
      if (e.k != k || e.c != cyc || e.v !== v || (k == K_DONE && e.p !== p)) begin
         n_fail++;
         $display("FAIL sb_%s: got %s cyc %0d val %h pos %h, expected %s cyc %0d val %h pos %h",
                  e.k.name(), k.name(), cyc, v, p, e.k.name(), e.c, e.v, e.p);
      end
   endtask

   always @(negedge CLK) begin
      if (bus.gnt !== pg) begin
         sb(K_GNT, 16'(bus.gnt), 16'h0);
         pg = bus.gnt;
      end
      if (bus.M_OUT !== pm) begin
         sb(K_MOUT, 16'(bus.M_OUT), 16'h0);
         pm = bus.M_OUT;
      end
      if (bus.done !== 3'b000) sb(K_DONE, 16'(bus.done), bus.pos);
      check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      check("done_in_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic till(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      tick();
      while (bus.busy && n < 200) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(bus.busy), 32'd0);
   endtask

   // Assert reset after an edge; outputs must clear without waiting for a clock.
   task automatic pulse_rst();
      RST = 1'b1;
      #1;
      check("rst_gnt",  32'(bus.gnt),   32'd0);
      check("rst_done", 32'(bus.done),  32'd0);
      check("rst_busy", 32'(bus.busy),  32'd0);
      check("rst_pos",  32'(bus.pos),   32'd0);
      check("rst_mout", 32'(bus.M_OUT), 32'd0);
      tick();
      RST = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d events pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int g, g2;
      logic [3:0]  rr_ph  [4];
      logic [15:0] rr_pos [4];
      rr_ph  = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
      rr_pos = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
      bus.EN = 1'b1; bus.req = 3'b000; bus.dir = 3'b000;
      bus.steps_qr = '0; bus.steps_geo = '0; bus.steps_gps = '0;
      #1;
      pulse_rst();
      tick();

      // single forward move; dir/steps changed after the grant must be ignored
      g = cyc + 1;
      bus.dir = 3'b001; bus.steps_qr = 16'd3; bus.req = 3'b001;
      expect_ev(K_GNT, g, 16'h1);
      expect_ev(K_MOUT, g + 4, 16'h1);
      expect_ev(K_MOUT, g + 8, 16'h2);
      expect_ev(K_MOUT, g + 12, 16'h4);
      expect_ev(K_DONE, g + 12, 16'h1, 16'd3);
      expect_ev(K_GNT, g + 13, 16'h0);
      tick();
      bus.steps_qr = 16'd7; bus.dir = 3'b000;
      till(g + 12);
      bus.req = 3'b000;
      wait_idle();
      check("t1_pos", 32'(bus.pos), 32'd3);
      check("t1_hold", 32'(bus.M_OUT), 32'h4);

      // reverse from reset, req dropped early
      expect_ev(K_MOUT, cyc, 16'h0);
      pulse_rst();
      g = cyc + 1;
      bus.dir = 3'b000; bus.steps_geo = 16'd2; bus.req = 3'b010;
      expect_ev(K_GNT, g, 16'h2);
      expect_ev(K_MOUT, g + 4, 16'h8);
      expect_ev(K_MOUT, g + 8, 16'h4);
      expect_ev(K_DONE, g + 8, 16'h2, 16'hFFFE);
      expect_ev(K_GNT, g + 9, 16'h0);
      till(g + 5);
      bus.req = 3'b000;
      wait_idle();
      check("t2_pos", 32'(bus.pos), 32'h0000FFFE);

      // zero-length move
      g = cyc + 1;
      bus.steps_gps = 16'd0; bus.req = 3'b100;
      expect_ev(K_GNT, g, 16'h4);
      expect_ev(K_DONE, g + 1, 16'h4, 16'hFFFE);
      expect_ev(K_GNT, g + 2, 16'h0);
      till(g + 1);
      bus.req = 3'b000;
      wait_idle();
      check("t3_pos", 32'(bus.pos), 32'h0000FFFE);
      check("t3_hold", 32'(bus.M_OUT), 32'h4);

      // round robin with all three held
      g = cyc + 1;
      bus.dir = 3'b111; bus.steps_qr = 16'd1; bus.steps_geo = 16'd1; bus.steps_gps = 16'd1;
      bus.req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         expect_ev(K_GNT, g + 8 * i, 16'(3'b001 << (i % 3)));
         expect_ev(K_MOUT, g + 8 * i + 4, 16'(rr_ph[i]));
         expect_ev(K_DONE, g + 8 * i + 4, 16'(3'b001 << (i % 3)), rr_pos[i]);
         expect_ev(K_GNT, g + 8 * i + 5, 16'h0);
      end
      till(g + 28);
      bus.req = 3'b000;
      wait_idle();

      // pause for 10 cycles after step 2
      expect_ev(K_MOUT, cyc, 16'h0);
      pulse_rst();
      g = cyc + 1;
      bus.dir = 3'b001; bus.steps_qr = 16'd4; bus.req = 3'b001;
      expect_ev(K_GNT, g, 16'h1);
      expect_ev(K_MOUT, g + 4, 16'h1);
      expect_ev(K_MOUT, g + 8, 16'h2);
      expect_ev(K_MOUT, g + 9, 16'h0);
      expect_ev(K_MOUT, g + 19, 16'h2);
      expect_ev(K_MOUT, g + 22, 16'h4);
      expect_ev(K_MOUT, g + 26, 16'h8);
      expect_ev(K_DONE, g + 26, 16'h1, 16'd4);
      expect_ev(K_GNT, g + 27, 16'h0);
      till(g + 9);
      bus.EN = 1'b0;
      till(g + 14);
      check("t5_busy_paused", 32'(bus.busy), 32'd1);
      check("t5_gnt_paused", 32'(bus.gnt), 32'd1);
      till(g + 19);
      bus.EN = 1'b1;
      till(g + 26);
      bus.req = 3'b000;
      wait_idle();
      check("t5_pos", 32'(bus.pos), 32'd4);

      // reset mid-move, req held through reset is granted afresh
      g = cyc + 1;
      bus.steps_qr = 16'd5; bus.req = 3'b001;
      expect_ev(K_GNT, g, 16'h1);
      expect_ev(K_MOUT, g + 4, 16'h1);
      till(g + 6);
      expect_ev(K_GNT, cyc, 16'h0);
      expect_ev(K_MOUT, cyc, 16'h0);
      bus.steps_qr = 16'd2;
      pulse_rst();
      g2 = cyc + 1;
      expect_ev(K_GNT, g2, 16'h1);
      expect_ev(K_MOUT, g2 + 4, 16'h1);
      expect_ev(K_MOUT, g2 + 8, 16'h2);
      expect_ev(K_DONE, g2 + 8, 16'h1, 16'd2);
      expect_ev(K_GNT, g2 + 9, 16'h0);
      till(g2 + 8);
      bus.req = 3'b000;
      wait_idle();
      check("t6_pos", 32'(bus.pos), 32'd2);

      tick(3);
      check("sb_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/stepper_move_arbiter.md
Name: stepper_move_arbiter

Overview:
- Shares the single full-step stepper phase driver between three move requesters: QR scanner (index 0), geomagnetic heading loop (index 1) and GPS latitude loop (index 2).
- Each requester asks for a signed move (direction plus step count). The block grants one requester at a time using round-robin and paces the steps with an internal step timer.
- Drives the one-hot phase output M_OUT and tracks absolute position.
- Sits between the sensor decision logic and the motor coil drivers.

Parameters:
- STEP_DIV, 1000, clock cycles per motor step (at least 2).
- CNT_W, 16, width of the per-request step count.
- POS_W, 16, width of the absolute position counter.
- SETTLE, 100, idle dead-time cycles after each move before re-arbitration (at least 1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  motor enable; low pauses motion and de-energises coils.
- req  input  3  request levels; bit0 QR, bit1 GEO, bit2 GPS.
- dir  input  3  per-requester direction; 1 = forward, 0 = reverse.
- steps_qr, steps_geo, steps_gps  input  CNT_W each  per-requester step count.
- gnt  output  3  one-hot grant.
- done  output  3  one-cycle completion pulse to the granted requester.
- busy  output  1  high in any state other than IDLE.
- pos  output  POS_W  absolute position, two's complement.
- M_OUT  output  4  coil phases [A+,A-,B+,B-].

Behaviour:
- Reset (async): all of the following are cleared immediately, including mid-move.
  - State goes to IDLE.
  - gnt, done, busy, pos, M_OUT and the phase register go to 0.
  - Round-robin pointer resets so QR is highest priority.
- States: IDLE, RUN, ZERO, SETTLE.
- IDLE (requires EN=1 and req≠0):
  - Winner is the first set bit starting at the index after the last-granted one (cyclic 0→1→2→0).
  - Latch the winner's dir and steps.
  - gnt is registered and rises one edge after req is sampled.
  - Pointer is updated to the winner.
  - If latched steps == 0, go to ZERO; otherwise go to RUN with the timer loaded to STEP_DIV-1.
- IDLE with EN=0: no arbitration.
- RUN, per edge with EN=1:
  - If timer ≠ 0, decrement it.
  - If timer == 0: advance the phase, decrement remaining, update pos ±1 (wraps modulo 2^POS_W), reload the timer.
  - The first step lands exactly STEP_DIV cycles after gnt rises; N steps complete STEP_DIV×N cycles after gnt.
  - On the edge that executes the last step, done[winner] rises. It stays high for exactly one cycle.
  - gnt drops on the edge after done, together with the move to SETTLE.
- ZERO: done pulses on the edge after the grant; no phase or pos change; then SETTLE.
- Phase sequence:
  - Forward: 0001→0010→0100→1000→0001.
  - Reverse: 1000→0100→0010→0001→1000.
  - From 0000 (post-reset): forward goes to 0001, reverse goes to 1000.
  - Any illegal value goes to 0000 (no step).
- Holding: the phase register keeps its value after a move (holding torque).
- EN low during RUN:
  - Timer, remaining and phase are frozen; M_OUT is forced to 0000.
  - gnt stays held.
  - When EN rises again, resume with the remaining timer count; no step is lost or added.
- EN low in IDLE or SETTLE: M_OUT forced to 0000; the SETTLE count continues.
- SETTLE: count SETTLE cycles, then IDLE. Arbitration happens on the first IDLE edge.
- Requester handshake:
  - req is a level and must be held until done.
  - req dropped before done does not abort the move.
  - A requester that keeps req high after done is re-arbitrated after SETTLE, behind the other pending requesters.
- Latching: dir and steps inputs are ignored after latching; changes mid-move have no effect.
- busy is a registered state decode.
- gnt is never multi-hot. done only asserts on the bit where gnt is set.

Test Plan:
(All scenarios use STEP_DIV=4, SETTLE=2.)
- Single move: req=001, dir[0]=1, steps_qr=3 → gnt=001 next edge; M_OUT 0001/0010/0100 at gnt+4/8/12; done=001 at gnt+12; pos=3; gnt=000 at gnt+13; M_OUT holds 0100.
- Reverse from reset: req=010, dir[1]=0, steps_geo=2 → M_OUT 1000 then 0100; pos=0xFFFE; done=010 once.
- Round-robin: req=111 held, every count 1 → grant order QR, GEO, GPS, QR; exactly one gnt bit high at any time; SETTLE gap of 2 cycles between moves.
- Zero-length: steps_gps=0 → done=100 one edge after gnt; M_OUT and pos unchanged.
- Pause: steps_qr=4; EN low for 10 cycles after step 2 → M_OUT=0000 during the pause; steps 3 and 4 resume 4-cycle spacing measured from resume minus elapsed timer; pos=4 at the end.
- Reset mid-move: RST pulsed during step 2 of 5 → immediately gnt=000, M_OUT=0000, pos=0, busy=0; req=001 after release is granted normally.
